lcd_scanout: RTL

LCD_SCANOUT -- requirements
Module: lcd_scanout

---
 rtl/lcd_pkg.sv | 15 +
 rtl/lcd_scanout.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD geometry constants and the scanout state encoding.
package lcd_pkg;

    localparam int         LCD_WIDTH      = 32;
    localparam int         LCD_HEIGHT     = 16;
    localparam logic [7:0] ICON_BASE_ADDR = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LATCH,
        ST_OUTPUT
    } scan_state_t;

endpackage

// File: rtl/lcd_scanout.sv
// Scans a 32x16 dot matrix plus icon bits out of nibble-wide VRAM
// as a valid/ready pixel stream, one VRAM read per pixel.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for frame_start; vram_address holds
// ST_ADDR   | vram_address presented for the current pixel
// ST_LATCH  | read data returning; bit selected and captured at the edge
// ST_OUTPUT | pixel_valid high until the downstream handshake
module lcd_scanout
    import lcd_pkg::*;
#(
    parameter int ICON_COUNT = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       frame_start,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] vram_address,
    input  logic [3:0] vram_q,
    output logic       pixel_valid,
    input  logic       pixel_ready,
    output logic       pixel,
    output logic [4:0] pixel_x,
    output logic [3:0] pixel_y,
    output logic       pixel_is_icon
);

    localparam logic [4:0] X_LAST    = 5'(LCD_WIDTH - 1);
    localparam logic [3:0] Y_LAST    = 4'(LCD_HEIGHT - 1);
    localparam logic [4:0] ICON_LAST = 5'(ICON_COUNT - 1);

    scan_state_t state;
    scan_state_t state_next;

    logic       handshake;
    logic       last_pixel;
    logic       done_next;
    logic [4:0] x_next;
    logic [3:0] y_next;
    logic       icon_next;
    logic [7:0] addr_next;
    logic [1:0] bit_sel;

    assign handshake  = (state == ST_OUTPUT) && pixel_ready;
    assign last_pixel = pixel_is_icon && (pixel_x == ICON_LAST);

    // Icons index nibbles four to an address; matrix rows share an
    // address in groups of four, the row's low bits picking the nibble bit.
    assign bit_sel = pixel_is_icon ? pixel_x[1:0] : pixel_y[1:0];

    always_comb begin
        x_next    = pixel_x;
        y_next    = pixel_y;
        icon_next = pixel_is_icon;
        if (pixel_is_icon) begin
            x_next = pixel_x + 5'd1;
        end else if (pixel_x == X_LAST) begin
            x_next = 5'd0;
            if (pixel_y == Y_LAST) begin
                y_next    = 4'd0;
                icon_next = 1'b1;
            end else begin
                y_next = pixel_y + 4'd1;
            end
        end else begin
            x_next = pixel_x + 5'd1;
        end
    end

    always_comb begin
        if (icon_next) begin
            addr_next = ICON_BASE_ADDR + {5'd0, x_next[4:2]};
        end else begin
            addr_next = {1'b0, y_next[3:2], x_next};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        busy        = (state != ST_IDLE);
        pixel_valid = (state == ST_OUTPUT);
        done_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                state_next = ST_LATCH;
            end
            ST_LATCH: begin
                state_next = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (handshake) begin
                    if (last_pixel) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_ADDR;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Position registers double as the pixel coordinate outputs, so they
    // only move on a handshake and stay stable while the sink stalls.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            frame_done    <= 1'b0;
            vram_address  <= 8'd0;
            pixel         <= 1'b0;
            pixel_x       <= 5'd0;
            pixel_y       <= 4'd0;
            pixel_is_icon <= 1'b0;
        end else begin
            frame_done <= done_next;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        pixel_x       <= 5'd0;
                        pixel_y       <= 4'd0;
                        pixel_is_icon <= 1'b0;
                        vram_address  <= 8'd0;
                    end
                end
                ST_LATCH: begin
                    pixel <= vram_q[bit_sel];
                end
                ST_OUTPUT: begin
                    if (handshake && !last_pixel) begin
                        pixel_x       <= x_next;
                        pixel_y       <= y_next;
                        pixel_is_icon <= icon_next;
                        vram_address  <= addr_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
